// File: rtl/light_crossfader.sv
// Registered RGB crossfader: button-stepped palette colour blended linearly with white,
// the blend weight m ramping toward the target selected by sel over 2**FADE_LOG2 cycles.
module light_crossfader #(
  parameter int CW        = 8,
  parameter int NCOL      = 6,
  parameter int FADE_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            button,
  output logic [3*CW-1:0] light,
  output logic [2:0]      colour_idx,
  output logic            fading
);

  localparam int MW = FADE_LOG2 + 1;
  localparam int IW = CW + FADE_LOG2 + 1;
  localparam logic [MW-1:0] STEPS = MW'(2 ** FADE_LOG2);
  localparam logic [IW-1:0] WFULL = IW'((2 ** CW) - 1);

  logic [MW-1:0]   m;
  logic [MW-1:0]   m_next;
  logic            btn_q;
  logic            step;
  logic [2:0]      idx_next;
  logic [2:0]      code;
  logic [3*CW-1:0] mix;

  // One channel of the blend; the palette channel is either full scale or zero.
  function automatic logic [CW-1:0] mix_ch(input logic on, input logic [MW-1:0] mv);
    logic [IW-1:0] sum;
    sum = WFULL * IW'(STEPS - mv) + (on ? WFULL : '0) * IW'(mv);
    return CW'(sum >> FADE_LOG2);
  endfunction

  always_comb begin
    step     = button & ~btn_q;
    code     = colour_idx + 3'd1;
    idx_next = colour_idx;
    if (step) begin
      idx_next = (colour_idx == 3'(NCOL - 1)) ? 3'd0 : colour_idx + 3'd1;
    end
  end

  // Weight walks toward STEPS while sel is high and toward 0 otherwise.
  always_comb begin
    m_next = m;
    if (sel && (m < STEPS)) begin
      m_next = m + MW'(1);
    end else if (!sel && (m != '0)) begin
      m_next = m - MW'(1);
    end
  end

  // Channel order {R,G,B} maps to code bits {2,1,0}.
  always_comb begin
    mix = '0;
    for (int ch = 0; ch < 3; ch++) begin
      mix[ch*CW +: CW] = mix_ch(code[ch], m);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_idx <= 3'd0;
      m          <= '0;
      btn_q      <= 1'b0;
      light      <= '1;
    end else begin
      colour_idx <= idx_next;
      m          <= m_next;
      btn_q      <= button;
      light      <= mix;
    end
  end

  assign fading = (m != '0) && (m != STEPS);

endmodule

// File: tb/tb_light_crossfader.sv
// Directed bench for light_crossfader: default build driven cycle by cycle against a
// reference model through an expected-light queue, plus a small-parameter instance.
module tb_light_crossfader;

  localparam int NCOL  = 6;
  localparam int STEPS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        button = 1'b0;
  logic [23:0] light;
  logic [2:0]  colour_idx;
  logic        fading;

  logic        sel2 = 1'b0;
  logic        button2 = 1'b0;
  logic [11:0] light2;
  logic [2:0]  idx2;
  logic        fading2;

  always #5 clk = ~clk;

  light_crossfader #(.CW(8), .NCOL(6), .FADE_LOG2(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .button(button),
    .light(light), .colour_idx(colour_idx), .fading(fading)
  );

  light_crossfader #(.CW(4), .NCOL(3), .FADE_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .sel(sel2), .button(button2),
    .light(light2), .colour_idx(idx2), .fading(fading2)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [23:0] exp_q[$];
  int          idx_mod = 0;
  int          m_mod   = 0;
  logic        btnq_mod = 1'b0;
  logic [23:0] pal [6] = '{24'h00FF00, 24'h00FFFF, 24'hFF0000,
                           24'hFF00FF, 24'hFFFF00, 24'h0000FF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] model_light(input int idx, input int m);
    int c;
    int p;
    logic [23:0] r;
    c = idx + 1;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      p = ((c >> ch) & 1) ? 255 : 0;
      r[ch*8 +: 8] = 8'((255 * (STEPS - m) + p * m) / STEPS);
    end
    return r;
  endfunction

  // One clock edge: model predicts, expectation is queued, DUT is sampled 1 ns after the edge.
  task automatic tick();
    if (rst) begin
      exp_q.push_back(24'hFFFFFF);
      idx_mod  = 0;
      m_mod    = 0;
      btnq_mod = 1'b0;
    end else begin
      exp_q.push_back(model_light(idx_mod, m_mod));
      if (button && !btnq_mod) idx_mod = (idx_mod == NCOL - 1) ? 0 : idx_mod + 1;
      btnq_mod = button;
      if (sel && m_mod < STEPS) m_mod = m_mod + 1;
      else if (!sel && m_mod > 0) m_mod = m_mod - 1;
    end
    @(posedge clk);
    #1;
    check("light", light, exp_q.pop_front());
    check("colour_idx", colour_idx, idx_mod);
    check("fading", fading, (m_mod != 0 && m_mod != STEPS));
  endtask

  initial begin
    // Reset acts before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_light", light, 24'hFFFFFF);
    check("rst_idx", colour_idx, 3'd0);
    check("rst_fading", fading, 1'b0);
    check("rst_light2", light2, 12'hFFF);
    tick();
    rst = 1'b0;

    // Settle on palette colour 0 (blue).
    sel = 1'b1;
    repeat (18) tick();
    check("settled_blue", light, 24'h0000FF);

    // Six single-cycle pulses walk the palette and wrap.
    for (int k = 0; k < 6; k++) begin
      button = 1'b1;
      tick();
      button = 1'b0;
      tick();
      check("pulse_idx", colour_idx, (k + 1) % 6);
      check("pulse_light", light, pal[k]);
    end

    // A held button steps once.
    button = 1'b1;
    repeat (20) tick();
    button = 1'b0;
    repeat (2) tick();
    check("held_idx", colour_idx, 3'd1);
    check("held_light", light, 24'h00FF00);

    for (int k = 0; k < 2; k++) begin
      button = 1'b1;
      tick();
      button = 1'b0;
      tick();
    end
    check("idx_red", colour_idx, 3'd3);

    // Bring m to 9 on red, then reset asynchronously mid-fade.
    sel = 1'b0;
    repeat (17) tick();
    sel = 1'b1;
    repeat (9) tick();
    check("m9_fading", fading, 1'b1);
    check("m9_light", light, 24'hFF7F7F);
    rst = 1'b1;
    #1;
    check("async_rst_light", light, 24'hFFFFFF);
    check("async_rst_idx", colour_idx, 3'd0);
    check("async_rst_fading", fading, 1'b0);
    sel = 1'b0;
    tick();
    rst = 1'b0;

    // Fade white -> blue.
    sel = 1'b1;
    tick();
    check("fade_start", fading, 1'b1);
    repeat (8) tick();
    check("fade_mid", light, 24'h7F7FFF);
    repeat (7) tick();
    check("fade_edge16_fading", fading, 1'b0);
    check("fade_edge16_light", light, 24'h0F0FFF);
    tick();
    check("fade_done", light, 24'h0000FF);

    // Reverse mid-fade.
    sel = 1'b0;
    repeat (17) tick();
    check("back_white", light, 24'hFFFFFF);
    sel = 1'b1;
    repeat (5) tick();
    check("rev_up5", light, 24'hBFBFFF);
    sel = 1'b0;
    repeat (6) tick();
    check("rev_white", light, 24'hFFFFFF);
    check("rev_fading", fading, 1'b0);

    // Step and sel change land on the same edge.
    button = 1'b1;
    sel = 1'b1;
    tick();
    button = 1'b0;
    repeat (3) tick();
    check("simul_idx", colour_idx, 3'd1);
    check("simul_light", light, 24'hCFFFCF);

    // Small build: CW=4, NCOL=3, FADE_LOG2=2.
    for (int k = 0; k < 3; k++) begin
      button2 = 1'b1;
      tick();
      button2 = 1'b0;
      tick();
      check("p2_idx", idx2, (k + 1) % 3);
    end
    sel2 = 1'b1;
    tick();
    check("p2_m0", light2, 12'hFFF);
    tick();
    check("p2_m1", light2, 12'hBBF);
    tick();
    check("p2_m2", light2, 12'h77F);
    check("p2_fading", fading2, 1'b1);
    tick();
    check("p2_full_fading", fading2, 1'b0);
    tick();
    check("p2_blue", light2, 12'h00F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
